sw_alloc_out_ctrl: RTL
======================

# sw_alloc_out_ctrl

Per-output-port switch allocator controller for the wormhole mesh router. It arbitrates round-robin among the five input ports (N, E, S, W, L) that request this output. It then holds a one-hot grant for the whole packet, from head flit to tail flit, and drives the select of the output's 5:1 one-hot flit mux. It also tracks downstream buffer credits, so a flit is only forwarded when the next router has space. One instance sits on each output port, between the input buffers/route computation and the crossbar mux.

## Interface
- `BUF_DEPTH`, default 4: downstream input-buffer depth, in flits; this is the initial credit count.
- `CW`, default 3: credit counter width; must satisfy `2^CW > BUF_DEPTH`.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 5: per-input request; bit i = input i's front flit is routed to this output. Bit order is 0=N, 1=E, 2=S, 3=W, 4=L.
- `sel_flit`, input, 8: the flit currently at the mux output. Bits [7:6] are the flit type: 01 head, 10 body, 11 tail, 00 single-flit packet (head+tail).
- `credit_in`, input, 1: one-cycle pulse; the downstream router freed one buffer slot.
- `grant`, output, 5: registered one-hot grant, or 0; drives the mux select directly.
- `pop`, output, 5: read strobe back to the granted input buffer; one-hot or 0.
- `flit_valid_out`, output, 1: `sel_flit` is valid on the output link this cycle.
- `busy`, output, 1: the controller is in the LOCKED state.
- `credits`, output, CW: current downstream credit count (for debug/verification).

## Operation
- Reset values: `grant`=0, `pop`=0, `flit_valid_out`=0, `busy`=0, `credits`=BUF_DEPTH, priority pointer `ptr`=0, state=IDLE.
- **State IDLE:**
  - If `req`≠0, pick the first set bit scanning circularly from `ptr` (`ptr`, `ptr`+1, …, mod 5).
  - Register that winner into `grant` and go to LOCKED.
  - If `req`=0, stay in IDLE with `grant`=0.
  - Arbitration does not depend on credits.
- **State LOCKED (grant on input g):**
  - Transfer condition: `xfer` = `req[g]` AND (`credits`≠0).
  - `pop` = `grant` when `xfer`, else 0.
  - `flit_valid_out` = `xfer`.
  - `pop` and `flit_valid_out` are combinational from registered state and inputs.
  - If `xfer` and `sel_flit[7:6]` is 11 or 00, the packet ends:
    - next state is IDLE;
    - `grant` clears to 0 next cycle;
    - `ptr` becomes (g+1) mod 5.
  - If `req[g]` drops mid-packet, stall: keep `grant` and hold LOCKED (wormhole). Other requesters are never granted until g's tail transfers.
  - `req` on other inputs is ignored while LOCKED.
- **Credit counter:**
  - `xfer` alone: −1.
  - `credit_in` alone: +1.
  - Both together: unchanged.
  - `credit_in` while `credits`=BUF_DEPTH and no `xfer`: ignored; saturates at BUF_DEPTH.
  - `credits` never goes below 0, because `xfer` requires `credits`≠0.
- `ptr` updates only on a tail transfer, never on a grant.
- Reset asserted mid-packet: the outputs and all state return to their reset values immediately (asynchronous). The partial packet is abandoned.

## Timing
- Grant latency: `req` sampled in IDLE at edge k gives `grant` valid after edge k.
  - The head flit can transfer in cycle k+1.
  - Minimum request-to-first-`flit_valid_out` latency is 1 cycle.
- Throughput: 1 flit per cycle while LOCKED, with `req[g]`=1 and `credits`>0.
- Packet turnaround:
  - tail transfers in cycle t → `grant`=0 in cycle t+1 (IDLE arbitration) → new `grant` in cycle t+2.
  - This gives one bubble cycle between packets.
- `credit_in` at edge k is usable for a transfer in the cycle after edge k.

## Test plan
- **Reset:** `rst_n`=0 → `grant`=0, `pop`=0, `flit_valid_out`=0, `credits`=4; deassert with `req`=0 → outputs stay 0.
- **Single 3-flit packet:** `req`=00010 (E), flits 01, 10, 11, `credit_in`=0 →
  - `grant`=00010 one cycle after `req`;
  - `pop`=00010 for 3 consecutive cycles;
  - `credits` 4→1;
  - `grant`=0 the cycle after the tail;
  - `ptr`=2.
- **Round-robin fairness:** `req`=11111 held, single-flit packets (type 00), credits replenished each cycle → grant order N, E, S, W, L, N, each separated by one IDLE cycle.
- **Wormhole lock:** grant S (00100) after its head flit. `req`=11011 for 3 cycles (S drops, others assert) → `grant` stays 00100, `pop`=0, `flit_valid_out`=0. Then S reasserts with the tail → transfer, then IDLE.
- **Credit stall:** 6-flit packet from L with BUF_DEPTH=4 and no `credit_in` → 4 transfers, then stall with `credits`=0 and `pop`=0. A `credit_in` pulse → exactly 1 further transfer. Simultaneous `credit_in` and `xfer` → `credits` unchanged.
- **Reset mid-packet:** assert `rst_n`=0 during body flits of W → `grant`=0 and `credits`=4 asynchronously. After release, `req`=00001 → N granted (`ptr`=0).

Source files
------------

// File: rtl/sw_alloc_out_ctrl.sv
// Per-output-port switch allocator: round-robin arbitration over five inputs,
// wormhole grant lock from head to tail, and downstream credit tracking.
module sw_alloc_out_ctrl #(
  parameter int BUF_DEPTH = 4,
  parameter int CW        = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [4:0]    req,
  input  logic [7:0]    sel_flit,
  input  logic          credit_in,
  output logic [4:0]    grant,
  output logic [4:0]    pop,
  output logic          flit_valid_out,
  output logic          busy,
  output logic [CW-1:0] credits
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t     state;
  logic [2:0] ptr;
  logic [4:0] winner;
  logic [2:0] grant_idx;
  logic [2:0] next_ptr;
  logic       xfer;
  logic       is_tail;

  // Circular priority scan starting at ptr; the first requester found wins.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int j = 0; j < 5; j++) begin
      idx = 3'((int'(ptr) + j) % 5);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int j = 0; j < 5; j++) begin
      if (grant[j]) grant_idx = 3'(j);
    end
  end

  assign next_ptr       = (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;
  assign is_tail        = (sel_flit[7:6] == 2'b11) || (sel_flit[7:6] == 2'b00);
  assign xfer           = (state == LOCKED) && ((req & grant) != 5'b0) && (credits != '0);
  assign pop            = xfer ? grant : 5'b0;
  assign flit_valid_out = xfer;
  assign busy           = (state == LOCKED);

  // The grant stays locked until the tail flit actually transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 5'b0) begin
            grant <= winner;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && is_tail) begin
            grant <= '0;
            state <= IDLE;
            ptr   <= next_ptr;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // A returned credit and a transfer in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= FULL;
    end else if (xfer && !credit_in) begin
      credits <= credits - ONE;
    end else if (credit_in && !xfer && (credits != FULL)) begin
      credits <= credits + ONE;
    end
  end

endmodule
